// File: rtl/game_timer_if.sv
// game_timer_if: control and status bundle between the game-control FSM and the round timer.
// The BCD digit signals exist only when GAME_TIMER_BCD_EN is defined.
interface game_timer_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             tick;
    logic             expired;
    logic             done;
    logic             warn;
`ifdef GAME_TIMER_BCD_EN
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
`endif

    modport master (
        output start, pause, load, load_value,
        input  count, running, tick, expired, done, warn
`ifdef GAME_TIMER_BCD_EN
        , bcd_tens, bcd_ones
`endif
    );

    modport slave (
        input  start, pause, load, load_value,
        output count, running, tick, expired, done, warn
`ifdef GAME_TIMER_BCD_EN
        , bcd_tens, bcd_ones
`endif
    );
endinterface

// File: rtl/game_timer.sv
// game_timer: prescaled round countdown with pause/resume, runtime reload, low-time warning and expiry pulse.
// Defining GAME_TIMER_BCD_EN adds a registered two-digit BCD readout of the count.
module game_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 6,
    parameter int START   = 60,
    parameter int WARN    = 10
) (
    input logic         clk,
    input logic         reset,
    game_timer_if.slave bus
);
    localparam int               DIV     = CLK_HZ / TICK_HZ;
    localparam int               PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    prescaler, prescaler_n;
    logic [WIDTH-1:0] count_n;
    logic             tick_n, expired_n;

    // Leaving PAUSED with pause low advances the prescaler on that same edge,
    // so a pause held N cycles delays expiry by exactly N cycles.
    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        count_n     = bus.count;
        tick_n      = 1'b0;
        expired_n   = 1'b0;
        if (bus.load) begin
            count_n     = bus.load_value;
            prescaler_n = '0;
            state_n     = (bus.load_value == '0) ? DONE : IDLE;
        end else if (bus.start) begin
            count_n     = START_V;
            prescaler_n = '0;
            state_n     = RUN;
        end else if (state == RUN || state == PAUSED) begin
            if (bus.pause) begin
                state_n = PAUSED;
            end else begin
                state_n = RUN;
                if (prescaler == PRE_MAX) begin
                    prescaler_n = '0;
                    tick_n      = 1'b1;
                    if (bus.count <= WIDTH'(1)) begin
                        count_n   = '0;
                        state_n   = DONE;
                        expired_n = (bus.count == WIDTH'(1));
                    end else begin
                        count_n = bus.count - WIDTH'(1);
                    end
                end else begin
                    prescaler_n = prescaler + PW'(1);
                end
            end
        end
    end

`ifdef GAME_TIMER_BCD_EN
    localparam logic [3:0] START_TENS = 4'(START / 10);
    localparam logic [3:0] START_ONES = 4'(START % 10);

    logic [3:0] tens_n, ones_n;

    always_comb begin
        tens_n = 4'd9;
        ones_n = 4'd9;
        if (int'(count_n) <= 99) begin
            tens_n = 4'(int'(count_n) / 10);
            ones_n = 4'(int'(count_n) % 10);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            bus.count   <= START_V;
            bus.tick    <= 1'b0;
            bus.expired <= 1'b0;
            bus.running <= 1'b0;
            bus.done    <= 1'b0;
            bus.warn    <= (START <= WARN);
`ifdef GAME_TIMER_BCD_EN
            bus.bcd_tens <= START_TENS;
            bus.bcd_ones <= START_ONES;
`endif
        end else begin
            state       <= state_n;
            prescaler   <= prescaler_n;
            bus.count   <= count_n;
            bus.tick    <= tick_n;
            bus.expired <= expired_n;
            bus.running <= (state_n == RUN);
            bus.done    <= (state_n == DONE);
            bus.warn    <= (count_n != '0) && (int'(count_n) <= WARN);
`ifdef GAME_TIMER_BCD_EN
            bus.bcd_tens <= tens_n;
            bus.bcd_ones <= ones_n;
`endif
        end
    end
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: scenario tasks plus randomized traffic checked against a cycle-progress reference model.
`timescale 1ns/1ps
module tb_game_timer;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int WIDTH   = 6;
    localparam int START   = 5;
    localparam int WARN    = 2;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    game_timer_if #(.WIDTH(WIDTH)) bus();

    game_timer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH), .START(START), .WARN(WARN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a live session accumulates unpaused cycles; every DIV of them removes one from the count.
    int m_count;
    int m_progress;
    bit m_live, m_run, m_done, m_tick, m_exp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count = START; m_progress = 0;
            m_live = 0; m_run = 0; m_done = 0; m_tick = 0; m_exp = 0;
        end else begin
            m_tick = 0;
            m_exp  = 0;
            if (bus.load) begin
                m_count = int'(bus.load_value);
                m_progress = 0; m_live = 0; m_run = 0;
                m_done = (m_count == 0);
            end else if (bus.start) begin
                m_count = START; m_progress = 0;
                m_live = 1; m_run = 1; m_done = 0;
            end else if (m_live) begin
                m_run = !bus.pause;
                if (!bus.pause) begin
                    m_progress++;
                    if (m_progress == DIV) begin
                        m_progress = 0;
                        m_tick = 1;
                        m_count--;
                        if (m_count == 0) begin
                            m_live = 0; m_run = 0; m_done = 1; m_exp = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [WIDTH+4:0] model_vec();
        return {WIDTH'(m_count), m_run, m_tick, m_exp, m_done, (m_count > 0 && m_count <= WARN)};
    endfunction

    logic [WIDTH+4:0] dut_vec;
    assign dut_vec = {bus.count, bus.running, bus.tick, bus.expired, bus.done, bus.warn};

    task automatic test_reset();
        bus.start = 0; bus.pause = 0; bus.load = 0; bus.load_value = '0;
        #1 reset = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== {6'd5, 5'b00000}) begin
            fails++; $display("FAIL reset_state got %b want %b", dut_vec, {6'd5, 5'b00000});
        end
        reset = 0;
        bus.pause = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("FAIL idle_pause_ignored got %b want %b", dut_vec, model_vec());
        end
        bus.pause = 0;
    endtask

    task automatic test_countdown();
        int exp_at = -1, warn_at = -1, ticks = 0;
        bus.start = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.start = 0;
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL countdown cycle %0d got %b want %b", k, dut_vec, model_vec());
            end
            if (bus.tick) ticks++;
            if (bus.expired && exp_at < 0) exp_at = k;
            if (bus.warn && warn_at < 0) warn_at = k;
        end
        checks++;
        if (exp_at != START * DIV) begin fails++; $display("FAIL countdown_expired_cycle got %0d want %0d", exp_at, START * DIV); end
        checks++;
        if (ticks != START) begin fails++; $display("FAIL countdown_ticks got %0d want %0d", ticks, START); end
        checks++;
        if (warn_at != (START - WARN) * DIV) begin fails++; $display("FAIL countdown_warn_cycle got %0d want %0d", warn_at, (START - WARN) * DIV); end
        checks++;
        if ({bus.done, bus.running, bus.count} !== {1'b1, 1'b0, 6'd0}) begin
            fails++; $display("FAIL countdown_final got %b want %b", {bus.done, bus.running, bus.count}, {1'b1, 1'b0, 6'd0});
        end
    endtask

    task automatic test_pause();
        int exp_at = -1;
        bus.start = 1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bus.start = 0;
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL pause cycle %0d got %b want %b", k, dut_vec, model_vec());
            end
            if (k == 35) begin
                checks++;
                if ({bus.count, bus.running, bus.tick} !== {6'd3, 2'b00}) begin
                    fails++; $display("FAIL pause_frozen got %b want %b", {bus.count, bus.running, bus.tick}, {6'd3, 2'b00});
                end
            end
            if (bus.expired && exp_at < 0) exp_at = k;
            if (k == 23) bus.pause = 1;
            if (k == 40) bus.pause = 0;
        end
        checks++;
        if (exp_at != 67) begin fails++; $display("FAIL pause_expired_cycle got %0d want 67", exp_at); end
    endtask

    task automatic test_load();
        bus.start = 1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 0;
        end
        checks++;
        if (bus.count !== 6'd3) begin fails++; $display("FAIL load_precount got %0d want 3", bus.count); end
        bus.load = 1; bus.load_value = 6'd12;
        @(negedge clk);
        bus.load = 0;
        checks++;
        if ({bus.count, bus.running, bus.tick, bus.expired, bus.done} !== {6'd12, 4'b0000}) begin
            fails++; $display("FAIL load_12 got %b want %b", {bus.count, bus.running, bus.tick, bus.expired, bus.done}, {6'd12, 4'b0000});
        end
        repeat (15) @(negedge clk);
        checks++;
        if (dut_vec !== {6'd12, 5'b00000}) begin fails++; $display("FAIL load_idle_hold got %b want %b", dut_vec, {6'd12, 5'b00000}); end
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        checks++;
        if ({bus.count, bus.running} !== {6'd5, 1'b1}) begin
            fails++; $display("FAIL load_then_start got %b want %b", {bus.count, bus.running}, {6'd5, 1'b1});
        end
        repeat (4) @(negedge clk);
        bus.load = 1; bus.load_value = '0;
        @(negedge clk);
        bus.load = 0;
        checks++;
        if ({bus.count, bus.done, bus.expired, bus.running} !== {6'd0, 3'b100}) begin
            fails++; $display("FAIL load_zero got %b want %b", {bus.count, bus.done, bus.expired, bus.running}, {6'd0, 3'b100});
        end
    endtask

    task automatic test_restart();
        int tick_at = -1;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        checks++;
        if ({bus.count, bus.running, bus.done} !== {6'd5, 2'b10}) begin
            fails++; $display("FAIL start_from_done got %b want %b", {bus.count, bus.running, bus.done}, {6'd5, 2'b10});
        end
        for (int k = 1; k < 45; k++) begin
            @(negedge clk);
            bus.start = 0;
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL restart cycle %0d got %b want %b", k, dut_vec, model_vec());
            end
            if (k > 31 && bus.tick && tick_at < 0) tick_at = k;
            if (k == 30) begin
                checks++;
                if (bus.count !== 6'd2) begin fails++; $display("FAIL restart_precount got %0d want 2", bus.count); end
                bus.start = 1;
            end
        end
        checks++;
        if (tick_at != 31 + DIV) begin fails++; $display("FAIL restart_next_tick got %0d want %0d", tick_at, 31 + DIV); end
    endtask

    task automatic test_reset_midrun();
        bus.start = 1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 0;
        end
        #2 reset = 1;
        #1;
        checks++;
        if (dut_vec !== {6'd5, 5'b00000}) begin
            fails++; $display("FAIL reset_async got %b want %b", dut_vec, {6'd5, 5'b00000});
        end
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== model_vec()) begin fails++; $display("FAIL reset_release got %b want %b", dut_vec, model_vec()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL random cycle %0d got %b want %b", k, dut_vec, model_vec());
            end
`ifdef GAME_TIMER_BCD_EN
            checks++;
            if ({bus.bcd_tens, bus.bcd_ones} !== {4'(m_count / 10), 4'(m_count % 10)}) begin
                fails++; $display("FAIL random_bcd cycle %0d got %h want %h", k, {bus.bcd_tens, bus.bcd_ones}, {4'(m_count / 10), 4'(m_count % 10)});
            end
`endif
            bus.start = ($urandom_range(0, 39) == 0);
            bus.load  = ($urandom_range(0, 79) == 0);
            bus.load_value = WIDTH'($urandom_range(0, 8));
            if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
        end
        bus.start = 0; bus.load = 0; bus.pause = 0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_load();
        test_restart();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/game_timer.md
# game_timer

Parametrised countdown timer for game rounds: loads a start value, decrements once per tick derived from the system clock by an internal prescaler, and flags expiry. It supports pause/resume, runtime reload, a low-time warning and an optional two-digit BCD readout. It sits between the game-control FSM (start/pause/load) and the score/display logic (count, warn, expired).

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- TICK_HZ, 1: decrement rate; DIV = CLK_HZ/TICK_HZ, integer and ≥ 2.
- WIDTH, 6: count width.
- START, 60: value loaded on reset and on start; 1 ≤ START ≤ 2^WIDTH−1.
- WARN, 10: warn asserts when 0 < count ≤ WARN.
- clk  in  1  system clock; all logic on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: load START, prescaler←0, enter RUN.
- pause  in  1  level: while high, RUN holds as PAUSED.
- load  in  1  pulse: count←load_value, prescaler←0, enter IDLE.
- load_value  in  WIDTH  value taken on load.
- count  out  WIDTH  remaining ticks.
- running  out  1  high in RUN only.
- tick  out  1  one-cycle pulse on each decrement.
- expired  out  1  one-cycle pulse when count reaches 0 from RUN.
- done  out  1  level, high in DONE.
- warn  out  1  low-time level.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset: IDLE, count=START, prescaler=0, tick=expired=done=running=0. warn=(START≤WARN).
- Per-cycle priority: load > start > pause > tick.
- IDLE: start→RUN. pause ignored.
- RUN: prescaler counts 0..DIV−1. At DIV−1 it wraps to 0, tick=1 and count decrements. If count was 1, count←0, state→DONE, expired=1 in the same registered cycle. pause high→PAUSED.
- PAUSED: prescaler and count frozen. pause low→RUN, and counting continues from the frozen prescaler value. start restarts into RUN even with pause high, and pause then takes effect next cycle.
- DONE: count=0, done=1. start→RUN with START. pause ignored.
- load in any state: count←load_value, state→IDLE, expired not pulsed. load_value=0 goes to DONE instead, with done=1 and no expired.
- start in RUN/PAUSED restarts: count←START, prescaler←0.
- Decrement never wraps below 0.
- warn, done and running are registered and derived from next state/count.

## Timing
- Outputs are registered. tick, expired and count update on the same edge.
- First tick occurs DIV cycles after the edge that samples start.
- Start to expired takes START×DIV cycles, excluding paused cycles.
- A pause asserted on the cycle the prescaler hits DIV−1 suppresses that tick (pause wins).
- Reset asserted mid-run takes effect immediately (async); the first operation is possible on the first clk edge after deassertion.

## Configuration
- GAME_TIMER_BCD_EN defined: adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered, equal to count/10 and count%10, and updated on the same edge as count. Requires START ≤ 99 and load_value ≤ 99; if load_value > 99 both digits read 9.
- GAME_TIMER_BCD_EN undefined: these ports and their logic are absent, and behaviour is otherwise identical.

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=6, START=5, WARN=2.
- Reset then start pulse → ticks 10 cycles apart; count 5,4,3,2,1,0; warn rises as count becomes 2; expired pulses once after 50 cycles; done=1, running=0.
- Start, run 23 cycles, pause high 17 cycles, then release → count holds 3 while paused; expired at cycle 67 from start.
- load with load_value=12 during RUN (count=3) → count=12, IDLE, no tick/expired; next start → count=5. load with load_value=0 → done=1, expired=0.
- start in DONE, and start mid-run at count=2 → count=5, prescaler restarted, next tick 10 cycles later.
- Assert reset at count=3 mid-run → count=5, all pulses 0, IDLE immediately without waiting for a clk edge.
- With GAME_TIMER_BCD_EN and START=60: after 13 ticks, count=47, bcd_tens=4, bcd_ones=7.
